// File: rtl/quadrature_decoder_8bit.sv
// Quadrature A/B decoder: synchronises and deglitches the encoder pins, then
// tracks an 8-bit modulo position with direction, step pulse and sticky error.
module quadrature_decoder_8bit #(
  parameter int FILTER = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       clr_err,
  output logic [7:0] Qout,
  output logic       updown,
  output logic       step,
  output logic       err
);

  localparam int CW = 4;
  localparam logic [CW-1:0] FILT = CW'(FILTER);

  typedef struct packed {
    logic up;
    logic dn;
    logic bad;
  } dec_t;

  logic [1:0][1:0] sync_pipe;
  logic [1:0]      ab_s;
  logic [1:0]      ab_f;
  logic [1:0]      cand;
  logic [CW-1:0]   cnt;
  logic            armed;
  logic            accept;
  logic [1:0]      delta;
  dec_t            dec;

  // Position of an {A,B} value along the up sequence 00->10->11->01.
  function automatic logic [1:0] gpos(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  assign ab_s = sync_pipe[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_pipe <= '0;
    end else begin
      sync_pipe[0] <= {enc_a, enc_b};
      sync_pipe[1] <= sync_pipe[0];
    end
  end

  // cnt counts consecutive samples of cand; reaching FILTER accepts it on the
  // following edge, so a change seen first at E0 lands at E0 + 2 + FILTER.
  assign accept = (cnt == FILT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ab_f  <= 2'b00;
      cand  <= 2'b00;
      cnt   <= '0;
      armed <= 1'b0;
    end else if (accept) begin
      ab_f  <= cand;
      cnt   <= '0;
      armed <= 1'b1;
    end else if (ab_s == ab_f) begin
      cnt <= '0;
    end else if (cnt == '0 || ab_s != cand) begin
      cand <= ab_s;
      cnt  <= CW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    delta   = gpos(cand) - gpos(ab_f);
    dec     = '0;
    dec.up  = accept && armed && (delta == 2'd1);
    dec.dn  = accept && armed && (delta == 2'd3);
    dec.bad = accept && armed && (delta == 2'd2);
  end

  // load overrides any step decoded in the same cycle; an error set beats clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Qout   <= 8'h00;
      updown <= 1'b0;
      step   <= 1'b0;
      err    <= 1'b0;
    end else begin
      step <= 1'b0;
      if (load) begin
        Qout <= load_val;
      end else if (dec.up) begin
        Qout   <= Qout + 8'd1;
        updown <= 1'b0;
        step   <= 1'b1;
      end else if (dec.dn) begin
        Qout   <= Qout - 8'd1;
        updown <= 1'b1;
        step   <= 1'b1;
      end
      if (dec.bad)
        err <= 1'b1;
      else if (clr_err)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quadrature_decoder_8bit.sv
// Self-checking bench for quadrature_decoder_8bit (FILTER = 2): vector table
// plus hand sequences, expected results queued at drive time and popped at output.
module tb_quadrature_decoder_8bit;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_a, enc_b, load, clr_err;
  logic [7:0] load_val;
  logic [7:0] Qout;
  logic       updown, step, err;

  quadrature_decoder_8bit #(.FILTER(2)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .Qout(Qout), .updown(updown), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ab;
    logic       ld;
    logic [7:0] lv;
    logic       clr;
    logic [7:0] q;
    logic       ud;
    logic       st;
    logic       er;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   nsteps = 0;
  logic prev_step = 1'b0;
  logic [7:0] cur_q;
  vec_t sb[$];
  vec_t tbl[12];
  logic [1:0] seq[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // step pulses are counted and must never appear on back-to-back cycles
  always @(negedge clk) begin
    if (reset === 1'b1 && step === 1'b1) begin
      nsteps++;
      checks++;
      if (prev_step) begin
        errors++;
        $display("FAIL step_back_to_back actual=1 expected=0");
      end
    end
    prev_step = step;
  end

  // Pins change after an edge; first sampled at E0, result due at E0 + 4.
  // ld/clr are presented at E0 + 4 so they coincide with the decode.
  task automatic apply(input vec_t v);
    vec_t e;
    sb.push_back(v);
    enc_a = v.ab[1];
    enc_b = v.ab[0];
    repeat (4) tick();
    chk("qout_before_latency", Qout, cur_q);
    chk("step_before_latency", step, 1'b0);
    load = v.ld; load_val = v.lv; clr_err = v.clr;
    tick();
    load = 1'b0; clr_err = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("qout", Qout, e.q);
      chk("updown", updown, e.ud);
      chk("step", step, e.st);
      chk("err", err, e.er);
      cur_q = e.q;
    end
    repeat (2) tick();
  endtask

  function automatic vec_t mk(input logic [1:0] ab, input logic ld, input logic [7:0] lv,
                              input logic clr, input logic [7:0] q, input logic ud,
                              input logic st, input logic er);
    vec_t v;
    v.ab = ab; v.ld = ld; v.lv = lv; v.clr = clr;
    v.q = q; v.ud = ud; v.st = st; v.er = er;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int s0;
    logic [7:0] q;
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;

    // starts at Qout=22, updown=1, pins 01
    tbl[0]  = mk(2'b10, 0, 8'h00, 0, 8'd22, 1, 0, 1);  // illegal 01->10
    tbl[1]  = mk(2'b10, 0, 8'h00, 1, 8'd22, 1, 0, 0);  // clear
    tbl[2]  = mk(2'b01, 0, 8'h00, 1, 8'd22, 1, 0, 1);  // illegal + clr: set wins
    tbl[3]  = mk(2'b01, 0, 8'h00, 1, 8'd22, 1, 0, 0);
    tbl[4]  = mk(2'b11, 0, 8'h00, 0, 8'd21, 1, 1, 0);  // down
    tbl[5]  = mk(2'b01, 1, 8'h80, 0, 8'h80, 1, 0, 0);  // up discarded by load
    tbl[6]  = mk(2'b00, 0, 8'h00, 0, 8'h81, 0, 1, 0);  // up
    tbl[7]  = mk(2'b11, 0, 8'h00, 0, 8'h81, 0, 0, 1);  // illegal 00->11
    tbl[8]  = mk(2'b11, 0, 8'h00, 1, 8'h81, 0, 0, 0);
    tbl[9]  = mk(2'b00, 1, 8'h55, 0, 8'h55, 0, 0, 1);  // illegal during load
    tbl[10] = mk(2'b00, 0, 8'h00, 1, 8'h55, 0, 0, 0);
    tbl[11] = mk(2'b00, 1, 8'h37, 0, 8'h37, 0, 0, 0);

    reset = 1'b0; enc_a = 1'b1; enc_b = 1'b1;
    load = 1'b0; load_val = 8'h00; clr_err = 1'b0;
    cur_q = 8'h00;
    repeat (3) tick();
    chk("reset_qout", Qout, 8'h00);
    chk("reset_updown", updown, 1'b0);
    chk("reset_step", step, 1'b0);
    chk("reset_err", err, 1'b0);

    // pins at 11 out of reset: silent arm
    reset = 1'b1;
    repeat (10) tick();
    chk("arm_qout", Qout, 8'h00);
    chk("arm_steps", nsteps, 0);
    chk("arm_err", err, 1'b0);
    apply(mk(2'b01, 0, 8'h00, 0, 8'd1, 0, 1, 0));

    // wrap: 32 up edges from 250
    apply(mk(2'b01, 1, 8'd250, 0, 8'd250, 0, 0, 0));
    s0 = nsteps;
    idx = 3;
    q = 8'd250;
    for (int i = 0; i < 32; i++) begin
      idx = (idx + 1) % 4;
      q = q + 8'd1;
      apply(mk(seq[idx], 0, 8'h00, 0, q, 0, 1, 0));
    end
    chk("wrap_qout", Qout, 8'd26);
    chk("wrap_steps", nsteps - s0, 32);
    for (int i = 0; i < 4; i++) begin
      idx = (idx + 3) % 4;
      q = q - 8'd1;
      apply(mk(seq[idx], 0, 8'h00, 0, q, 1, 1, 0));
    end
    chk("reverse_qout", Qout, 8'd22);
    chk("reverse_updown", updown, 1'b1);

    for (int i = 0; i < 12; i++) apply(tbl[i]);

    // one-cycle glitch on A: 00 -> 10 -> 00
    s0 = nsteps;
    enc_a = 1'b1;
    tick();
    enc_a = 1'b0;
    repeat (8) tick();
    chk("glitch_qout", Qout, 8'h37);
    chk("glitch_steps", nsteps - s0, 0);
    chk("glitch_err", err, 1'b0);

    // 4-cycle hold is counted exactly at E0 + 4
    apply(mk(2'b10, 0, 8'h00, 0, 8'h38, 0, 1, 0));
    apply(mk(2'b10, 1, 8'h37, 0, 8'h37, 0, 0, 0));

    // async reset while a 10->11 step is being filtered
    enc_a = 1'b1; enc_b = 1'b1;
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    chk("async_reset_qout", Qout, 8'h00);
    chk("async_reset_step", step, 1'b0);
    chk("async_reset_err", err, 1'b0);
    chk("async_reset_updown", updown, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    cur_q = 8'h00;
    s0 = nsteps;
    repeat (10) tick();
    chk("rearm_qout", Qout, 8'h00);
    chk("rearm_steps", nsteps - s0, 0);
    apply(mk(2'b01, 0, 8'h00, 0, 8'd1, 0, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
